// File: rtl/fir_param_pipelined.sv
// fir_param_pipelined: parametrised N-tap pipelined FIR engine, memory to memory.
// Reads sample_count samples through RAM port A and writes filtered results through port B.
// Pipeline: read address -> RAM data -> delay line -> product/adder-tree register -> scale/saturate/write register.
// Build option: define FIR_ROUND_EN to add 2**(SHIFT-1) before the output shift (round half up).
module fir_param_pipelined #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 5,
    parameter int ADDR_W = 10,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] input_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [ADDR_W-1:0] sample_count,
    input  logic              coef_we,
    input  logic [3:0]        coef_idx,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr_a,
    input  logic [DATA_W-1:0] mem_data_out_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [DATA_W-1:0] mem_data_in_b,
    output logic              mem_we_b
);

    localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS);
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef FIR_ROUND_EN
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] ROUND_K = (SHIFT > 0) ? (EXT_W'(1) << RS) : '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        out_base_q, count_q, rd_cnt_q, wr_cnt_q;
    logic signed [COEF_W-1:0] h_q    [NTAPS];
    logic signed [DATA_W-1:0] x_dl_q [NTAPS];
    logic                     v1_q, v2_q, v3_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [EXT_W-1:0]  scaled;
    logic [DATA_W-1:0]        sat_d;
    logic                     start_ok, last_rd, last_wr;

    assign busy     = (state_q != S_IDLE);
    assign start_ok = (state_q == S_IDLE) && start;
    assign last_rd  = (state_q == S_RUN) && (rd_cnt_q == count_q);
    assign last_wr  = mem_we_b && (wr_cnt_q == count_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: a zero-length run skips straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (sample_count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_rd) state_d = S_DRAIN;
            S_DRAIN: if (last_wr) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch run parameters on start and step the read address once per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_base_q <= '0;
            count_q    <= '0;
            rd_cnt_q   <= '0;
            mem_addr_a <= '0;
        end else if (start_ok) begin
            out_base_q <= output_addr;
            count_q    <= sample_count;
            rd_cnt_q   <= ADDR_W'(1);
            mem_addr_a <= input_addr;
        end else if ((state_q == S_RUN) && !last_rd) begin
            rd_cnt_q   <= rd_cnt_q + ADDR_W'(1);
            mem_addr_a <= mem_addr_a + ADDR_W'(1);
        end
    end

    // Valid bits follow each sample down the pipe; delay line shifts in RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) x_dl_q[i] <= '0;
        end else begin
            v1_q <= (state_q == S_RUN);
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (start_ok) begin
                for (int i = 0; i < NTAPS; i++) x_dl_q[i] <= '0;
            end else if (v1_q) begin
                x_dl_q[0] <= mem_data_out_a;
                for (int i = 1; i < NTAPS; i++) x_dl_q[i] <= x_dl_q[i-1];
            end
        end
    end

    // Full-precision multiply-accumulate over all taps
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < NTAPS; i++)
            acc_d = acc_d + ACC_W'(h_q[i]) * ACC_W'(x_dl_q[i]);
    end

    // Accumulator pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    // Optional rounding, arithmetic shift, then clamp to the output range
    always_comb begin
        scaled = EXT_W'(acc_q);
`ifdef FIR_ROUND_EN
        scaled = scaled + ROUND_K;
`endif
        scaled = scaled >>> SHIFT;
        if (scaled > SAT_MAX)      sat_d = SAT_MAX[DATA_W-1:0];
        else if (scaled < SAT_MIN) sat_d = SAT_MIN[DATA_W-1:0];
        else                       sat_d = scaled[DATA_W-1:0];
    end

    // Write stage: one result per valid sample at output_addr + write index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_b      <= 1'b0;
            mem_addr_b    <= '0;
            mem_data_in_b <= '0;
            wr_cnt_q      <= '0;
        end else begin
            mem_we_b <= v3_q;
            if (start_ok) begin
                wr_cnt_q <= '0;
            end else if (v3_q) begin
                mem_addr_b    <= out_base_q + wr_cnt_q;
                mem_data_in_b <= sat_d;
                wr_cnt_q      <= wr_cnt_q + ADDR_W'(1);
            end
        end
    end

    // Coefficient bank: writable only while idle, out-of-range indices dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) h_q[i] <= '0;
        end else if (coef_we && !busy) begin
            for (int i = 0; i < NTAPS; i++)
                if (coef_idx == 4'(i)) h_q[i] <= coef_data;
        end
    end

    // Sticky done: set when DONE hands back to IDLE, cleared by the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 done <= 1'b0;
        else if (start_ok)          done <= 1'b0;
        else if (state_q == S_DONE) done <= 1'b1;
    end

endmodule

// File: tb/tb_fir_param_pipelined.sv
// tb_fir_param_pipelined: scoreboard bench for fir_param_pipelined with a behavioural RAM
// and an arithmetic reference model (sum of products, shift, clamp).
module tb_fir_param_pipelined;

    localparam int DATA_W   = 8;
    localparam int COEF_W   = 8;
    localparam int NTAPS    = 5;
    localparam int ADDR_W   = 10;
    localparam int SHIFT    = 1;
    localparam int MEM_SIZE = 1 << ADDR_W;
    localparam int YMAX     = (1 << (DATA_W - 1)) - 1;
    localparam int YMIN     = -(1 << (DATA_W - 1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              coef_we = 1'b0;
    logic [ADDR_W-1:0] input_addr = '0;
    logic [ADDR_W-1:0] output_addr = '0;
    logic [ADDR_W-1:0] sample_count = '0;
    logic [3:0]        coef_idx = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              busy, done, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
    logic [DATA_W-1:0] mem_data_out_a, mem_data_in_b;

    logic [DATA_W-1:0] mem [MEM_SIZE];
    logic              tb_we = 1'b0;
    logic [ADDR_W-1:0] tb_addr = '0;
    logic [DATA_W-1:0] tb_data = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int tb_h [NTAPS];

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t wr_q [$];
    exp_t rd_q [$];

    fir_param_pipelined #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .ADDR_W(ADDR_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .input_addr(input_addr),
        .output_addr(output_addr),
        .sample_count(sample_count),
        .coef_we(coef_we),
        .coef_idx(coef_idx),
        .coef_data(coef_data),
        .busy(busy),
        .done(done),
        .mem_addr_a(mem_addr_a),
        .mem_data_out_a(mem_data_out_a),
        .mem_addr_b(mem_addr_b),
        .mem_data_in_b(mem_data_in_b),
        .mem_we_b(mem_we_b)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM: registered read on A, write on B, plus a bench loading port
    always @(posedge clk) begin
        mem_data_out_a <= mem[mem_addr_a];
        if (mem_we_b) mem[mem_addr_b] <= mem_data_in_b;
        if (tb_we)    mem[tb_addr] <= tb_data;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: y[k] = clamp((sum h[i]*x[k-i] (+ half)) >>> SHIFT), x[n<0] = 0
    function automatic int refY(input int xs[$], input int k);
        int acc;
        acc = 0;
        for (int i = 0; i < NTAPS; i++)
            if (k - i >= 0) acc += tb_h[i] * xs[k-i];
`ifdef FIR_ROUND_EN
        acc += 1 << (SHIFT - 1);
`endif
        acc = acc >>> SHIFT;
        if (acc > YMAX) acc = YMAX;
        if (acc < YMIN) acc = YMIN;
        return acc;
    endfunction

    // Monitor: pops expected reads by cycle and expected writes whenever mem_we_b is seen
    always @(negedge clk) begin
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            checkOutput("read_addr", int'(mem_addr_a), rd_q[0].addr);
            void'(rd_q.pop_front());
        end
        if (mem_we_b) begin
            if (wr_q.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = wr_q.pop_front();
                checkOutput("write_addr", int'(mem_addr_b), e.addr);
                checkOutput("write_data", int'($signed(mem_data_in_b)), e.data);
                checkOutput("write_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic loadCoefs(input int hs[NTAPS]);
        for (int i = 0; i < NTAPS; i++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_idx  = 4'(i);
            coef_data = COEF_W'(hs[i]);
            tb_h[i]   = hs[i];
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Load samples, queue expected reads/writes, pulse start, then scramble the latched inputs
    task automatic applyStimulus(input int in_base, input int out_base, input int xs[$]);
        int n;
        int t0;
        exp_t e;
        n = xs.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tb_we   = 1'b1;
            tb_addr = ADDR_W'((in_base + k) % MEM_SIZE);
            tb_data = DATA_W'(xs[k]);
        end
        @(negedge clk);
        tb_we = 1'b0;
        t0 = cyc + 1;
        for (int k = 0; k < n; k++) begin
            e.addr = (in_base + k) % MEM_SIZE;
            e.data = 0;
            e.cyc  = t0 + k;
            rd_q.push_back(e);
            e.addr = (out_base + k) % MEM_SIZE;
            e.data = refY(xs, k);
            e.cyc  = t0 + 4 + k;
            wr_q.push_back(e);
        end
        input_addr   = ADDR_W'(in_base);
        output_addr  = ADDR_W'(out_base);
        sample_count = ADDR_W'(n);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("done_cleared_on_start", int'(done), 0);
        input_addr   = ADDR_W'($urandom);
        output_addr  = ADDR_W'($urandom);
        sample_count = ADDR_W'($urandom);
    endtask

    task automatic waitDone(input int limit);
        int i;
        i = 0;
        while (!done && i < limit) begin
            @(negedge clk);
            i++;
        end
        checkOutput("done_set", int'(done), 1);
        checkOutput("busy_low_when_done", int'(busy), 0);
        checkOutput("writes_outstanding", wr_q.size(), 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int xs[$];
        int hs[NTAPS];
        int inb;
        int n;
        int seen;

        for (int i = 0; i < NTAPS; i++) tb_h[i] = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_we", int'(mem_we_b), 0);
        checkOutput("reset_addr_a", int'(mem_addr_a), 0);
        checkOutput("reset_addr_b", int'(mem_addr_b), 0);
        checkOutput("reset_data_b", int'(mem_data_in_b), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse response; coefficients doubled so SHIFT=1 yields 1,2,3,2,1,0,0
        $display("[TB] impulse response");
        hs = '{2, 4, 6, 4, 2};
        loadCoefs(hs);
        xs = '{1, 0, 0, 0, 0, 0, 0};
        applyStimulus(16, 100, xs);
        waitDone(40);

        // Saturation at both rails
        $display("[TB] saturation");
        for (int i = 0; i < NTAPS; i++) hs[i] = 127;
        loadCoefs(hs);
        xs = {};
        for (int k = 0; k < 8; k++) xs.push_back(127);
        applyStimulus(200, 300, xs);
        waitDone(40);
        xs = {};
        for (int k = 0; k < 8; k++) xs.push_back(-128);
        applyStimulus(200, 300, xs);
        waitDone(40);

        // Shift with odd values of both signs
        $display("[TB] shift and rounding");
        hs = '{1, 0, 0, 0, 0};
        loadCoefs(hs);
        xs = '{3, -3};
        applyStimulus(40, 50, xs);
        waitDone(40);

        // Zero-length run: done two edges after start, no traffic
        $display("[TB] zero count");
        xs = {};
        applyStimulus(60, 70, xs);
        @(negedge clk);
        checkOutput("zero_count_done", int'(done), 1);
        checkOutput("zero_count_busy", int'(busy), 0);

        // Out-of-range coefficient index while idle must not alias onto a real tap
        @(negedge clk);
        coef_we = 1'b1; coef_idx = 4'd9; coef_data = 8'd77;
        @(negedge clk);
        coef_we = 1'b0;

        // start and coef_we pulsed mid-run must be ignored
        $display("[TB] writes while busy");
        hs = '{1, 2, 3, 2, 1};
        loadCoefs(hs);
        xs = {};
        for (int k = 0; k < 10; k++) xs.push_back(int'($urandom_range(255)) - 128);
        applyStimulus(400, 500, xs);
        coef_we = 1'b1; coef_idx = 4'd0; coef_data = 8'd100;
        start = 1'b1; input_addr = 10'd7; sample_count = 10'd3;
        @(negedge clk);
        coef_we = 1'b0; start = 1'b0;
        waitDone(60);
        applyStimulus(400, 520, xs);
        waitDone(60);

        // Address wrap on both ports
        $display("[TB] address wrap");
        xs = '{5, -7, 9, 11};
        applyStimulus(1022, 1023, xs);
        waitDone(40);

        // Random coefficients, samples, lengths and bases
        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NTAPS; i++)
                hs[i] = (r < 3) ? int'($urandom_range(15)) - 8 : int'($urandom_range(255)) - 128;
            loadCoefs(hs);
            n = int'($urandom_range(24, 1));
            xs = {};
            for (int k = 0; k < n; k++) xs.push_back(int'($urandom_range(255)) - 128);
            inb = int'($urandom_range(MEM_SIZE - 1));
            applyStimulus(inb, (inb + 512) % MEM_SIZE, xs);
            waitDone(n + 40);
        end

        // Reset mid-run while a write is on the bus
        $display("[TB] reset mid-run");
        hs = '{2, 4, 6, 4, 2};
        loadCoefs(hs);
        xs = {};
        xs.push_back(1);
        for (int k = 1; k < 20; k++) xs.push_back(0);
        applyStimulus(600, 700, xs);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_we_b) seen = 1;
        end
        checkOutput("write_seen_before_reset", seen, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we_async", int'(mem_we_b), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < NTAPS; i++) tb_h[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("no_write_after_abort", int'(mem_we_b), 0);

        // Coefficients cleared by reset: every output is zero
        xs = '{50, -60, 70, -80, 90, 100};
        applyStimulus(800, 900, xs);
        waitDone(40);

        // Reload and repeat the impulse test
        hs = '{2, 4, 6, 4, 2};
        loadCoefs(hs);
        xs = '{1, 0, 0, 0, 0, 0, 0};
        applyStimulus(16, 100, xs);
        waitDone(40);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
